stopwatch_key_ctrl: RTL
=======================

Name: stopwatch_key_ctrl

Overview:
- Control stage directly downstream of the push-button debouncers in the stop_watch design.
- Consumes two debounced, active-low key levels (start/stop and lap/reset) and detects press edges.
- Runs the stopwatch mode FSM and drives the time counter (run enable, clear) and the display (freeze, lap strobe/count).
- All logic is on the single system clock; the inputs are already synchronous to it.

Parameters:
- LONG_CYC, 100000000, consecutive low cycles on key_lr_n that form a long press (2 s at 50 MHz); legal range 2..2^32-1
- CNT_W, 32, width of the long-press counter; must hold LONG_CYC

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- key_ss_n  input  1  debounced start/stop key level, 0 = pressed
- key_lr_n  input  1  debounced lap/reset key level, 0 = pressed
- run  output  1  time-counter count enable
- freeze  output  1  display hold; display shows latched lap time while 1
- clr  output  1  one-cycle pulse; time counter clears to zero
- lap_stb  output  1  one-cycle pulse; display latches current time
- lap_cnt  output  4  laps taken since last clear, saturating
- state  output  2  current FSM state (IDLE=0, RUN=1, LAP=2, PAUSE=3)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=IDLE, run=0, freeze=0, clr=0, lap_stb=0, lap_cnt=0, long counter=0.
  - Edge-detect registers load the current key levels, so a key already held through reset release does not produce a press.
- Press detection:
  - ss_press = prev_ss & ~key_ss_n; lr_press = prev_lr & ~key_lr_n; evaluated combinationally each cycle.
  - prev_* registers update every cycle.
  - Release (0->1) produces no event.
- Latency: all outputs are registered. The cycle after the first sampled low, the new state, run and freeze are valid, and clr or lap_stb is high for exactly that one cycle.
- run = 1 in RUN and LAP, otherwise 0. freeze = 1 only in LAP.
- Transitions (anything not listed holds state):
  - IDLE: ss_press -> RUN. lr_press ignored.
  - RUN: ss_press -> PAUSE. lr_press -> LAP, with lap_stb pulse and lap_cnt += 1 (saturates at 15).
  - LAP: lr_press -> RUN (unfreeze). ss_press -> PAUSE.
  - PAUSE: ss_press -> RUN. lr_press -> IDLE with clr pulse; lap_cnt <= 0 in the same cycle.
- Simultaneous ss_press and lr_press in the same cycle: ss_press wins; the lr event is discarded, not queued.
- Holding a key generates exactly one press event; a new event requires release and re-press.
- rst asserted mid-operation, including during a clr/lap_stb cycle or a long-press count: all state returns to reset values on that edge. No pulse is emitted in the reset cycle.

Optional Feature:
- Macro: STOPWATCH_KEY_LONGPRESS_EN.
- Enabled:
  - Counter increments each cycle key_lr_n = 0; it resets to 0 when key_lr_n = 1.
  - When the counter reaches LONG_CYC-1 while key_lr_n is still 0: next cycle state=IDLE, clr pulse, lap_cnt=0, from any state.
  - Counter saturates, so only one long-press clear per hold.
  - The short-press action on the initial edge still executes normally.
  - If a long-press fire coincides with an ss_press, the long-press wins.
- Disabled: counter logic absent; behaviour exactly as described in Behaviour.

Test Plan (LONG_CYC=8 in simulation):
- Reset with key_ss_n held 0, release rst -> no transition: state=0, run=0. Release then press ss -> one cycle after the first low sample: state=1, run=1.
- From RUN press lr, press lr again, press lr again -> lap_stb one-cycle pulses; state sequence 2,1,2; freeze 1,0,1; lap_cnt=2; run stays 1 throughout.
- From RUN press ss, then press lr -> state 3 with run=0, then state 0 with one clr pulse and lap_cnt=0.
- Drive ss and lr low in the same cycle while in RUN -> state=3, no lap_stb, lap_cnt unchanged. Then release only lr and re-press lr -> IDLE with clr pulse.
- Sixteen RUN->LAP->RUN cycles -> lap_cnt saturates at 15 and never wraps to 0.
- Longpress enabled: hold lr low 20 cycles while in RUN -> cycle 1: LAP with lap_stb pulse; cycle 8: IDLE with a single clr pulse; no further clr until release. Longpress disabled: same stimulus -> remains in LAP with no clr pulse.

Source files
------------

// File: rtl/stopwatch_key_ctrl.sv
// stopwatch_key_ctrl
//   Key-handling controller that sits after the push-button debouncers.
//   It detects press edges on the two active-low keys, runs the stopwatch
//   mode FSM, and drives the time counter and the display.
//
//   Optional build macro: STOPWATCH_KEY_LONGPRESS_EN
//     When defined, holding lap/reset low for LONG_CYC cycles forces a
//     clear from any state.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   key_ss_n in   debounced start/stop level (0 = pressed)
//   key_lr_n in   debounced lap/reset level (0 = pressed)
//   run      out  time-counter count enable
//   freeze   out  display hold (shows latched lap time)
//   clr      out  one-cycle clear pulse to the time counter
//   lap_stb  out  one-cycle pulse, display latches current time
//   lap_cnt  out  laps since last clear, saturates at 15
//   state    out  FSM state (IDLE=0, RUN=1, LAP=2, PAUSE=3)
//
// state | meaning
// IDLE  | cleared, counter stopped
// RUN   | counting, display live
// LAP   | counting, display frozen on lap time
// PAUSE | counter stopped, time retained
module stopwatch_key_ctrl #(
  parameter int unsigned LONG_CYC = 100000000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss_n,
  input  logic       key_lr_n,
  output logic       run,
  output logic       freeze,
  output logic       clr,
  output logic       lap_stb,
  output logic [3:0] lap_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t     state_q;
  logic       run_q, freeze_q, clr_q, lap_stb_q;
  logic [3:0] lap_cnt_q;
  logic       prev_ss_q, prev_lr_q;
  logic       ss_press, lr_press;
  logic       long_fire;

  assign ss_press = prev_ss_q & ~key_ss_n;
  assign lr_press = prev_lr_q & ~key_lr_n;

`ifdef STOPWATCH_KEY_LONGPRESS_EN
  logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;

  // Counter parks at LONG_CYC so the fire compare matches only once per hold.
  always_comb begin
    lp_cnt_d = lp_cnt_q;
    if (key_lr_n)
      lp_cnt_d = '0;
    else if (lp_cnt_q != CNT_W'(LONG_CYC))
      lp_cnt_d = lp_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) lp_cnt_q <= '0;
    else     lp_cnt_q <= lp_cnt_d;
  end

  assign long_fire = ~key_lr_n & (lp_cnt_q == CNT_W'(LONG_CYC - 1));
`else
  logic unused_lp_params;
  assign unused_lp_params = (LONG_CYC > 32'd1) && (CNT_W > 32'd0);
  assign long_fire = 1'b0;
`endif

  // Priority: long-press clear, then start/stop, then lap/reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      freeze_q  <= 1'b0;
      clr_q     <= 1'b0;
      lap_stb_q <= 1'b0;
      lap_cnt_q <= 4'd0;
      // Load current levels so a key held through reset is not a press.
      prev_ss_q <= key_ss_n;
      prev_lr_q <= key_lr_n;
    end else begin
      prev_ss_q <= key_ss_n;
      prev_lr_q <= key_lr_n;
      clr_q     <= 1'b0;
      lap_stb_q <= 1'b0;
      if (long_fire) begin
        state_q   <= ST_IDLE;
        run_q     <= 1'b0;
        freeze_q  <= 1'b0;
        clr_q     <= 1'b1;
        lap_cnt_q <= 4'd0;
      end else if (ss_press) begin
        case (state_q)
          ST_RUN, ST_LAP: begin
            state_q  <= ST_PAUSE;
            run_q    <= 1'b0;
            freeze_q <= 1'b0;
          end
          default: begin
            state_q  <= ST_RUN;
            run_q    <= 1'b1;
            freeze_q <= 1'b0;
          end
        endcase
      end else if (lr_press) begin
        case (state_q)
          ST_RUN: begin
            state_q   <= ST_LAP;
            run_q     <= 1'b1;
            freeze_q  <= 1'b1;
            lap_stb_q <= 1'b1;
            if (lap_cnt_q != 4'd15) lap_cnt_q <= lap_cnt_q + 4'd1;
          end
          ST_LAP: begin
            state_q  <= ST_RUN;
            run_q    <= 1'b1;
            freeze_q <= 1'b0;
          end
          ST_PAUSE: begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            freeze_q  <= 1'b0;
            clr_q     <= 1'b1;
            lap_cnt_q <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign run     = run_q;
  assign freeze  = freeze_q;
  assign clr     = clr_q;
  assign lap_stb = lap_stb_q;
  assign lap_cnt = lap_cnt_q;
  assign state   = state_q;

endmodule
